alu_flag_commit_stage: RTL and testbench

- Execute-to-writeback stage directly downstream of the ALU in the mock ARMv7-M core.
- Captures the ALU result and NZCV flags and evaluates the instruction's 4-bit ARM condition code against the architectural APSR flags.
- Commits flags to the APSR when requested and the condition passes.
- Forwards the result to writeback through a 2-entry valid/ready skid buffer, giving full throughput with registered in_ready.

---
 rtl/alu_flag_commit_stage.sv | 156 +++++++++++++++
 tb/tb_alu_flag_commit_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_commit_stage.sv
// ALU flag commit stage: evaluates ARM condition codes against the APSR, commits NZCV,
// and forwards results through a 2-entry skid buffer. Optional MSR write port: APSR_MSR_WRITE_EN.
module alu_flag_commit_stage #(
  parameter int              DATA_WIDTH     = 32,
  parameter int              REG_ADDR_WIDTH = 4,
  parameter logic [3:0]      APSR_RESET     = 4'b0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_result,
  input  logic [3:0]                in_flags,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic [3:0]                in_cond,
  input  logic                      in_set_flags,
  input  logic                      in_logical,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_wr_en,
  output logic [3:0]                apsr_nzcv
`ifdef APSR_MSR_WRITE_EN
  ,
  input  logic                      apsr_wr_en,
  input  logic [3:0]                apsr_wr_data
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

  buf_state_t                state_reg, state_next;
  logic                      in_ready_reg;
  logic [3:0]                apsr_reg, apsr_upd, apsr_next;
  logic [DATA_WIDTH-1:0]     out_result_reg, skid_result_reg;
  logic [REG_ADDR_WIDTH-1:0] out_rd_reg, skid_rd_reg;
  logic                      out_wr_en_reg, skid_wr_en_reg;
  logic                      accept, cond_pass, flag_commit;
  logic                      load_out_in, load_out_skid, load_skid;
  logic [3:0]                flag_we;
  logic                      flag_n, flag_z, flag_c, flag_v;

  assign accept = in_valid & in_ready_reg & ~flush;
  assign {flag_n, flag_z, flag_c, flag_v} = apsr_reg;

  always_comb begin
    cond_pass = 1'b1;
    case (in_cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      default: cond_pass = 1'b1;
    endcase
  end

  // Logical ops update only N and Z; C and V keep their previous value.
  assign flag_commit = accept & cond_pass & in_set_flags;
  assign flag_we     = {{2{flag_commit}}, {2{flag_commit & ~in_logical}}};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_apsr_bit
      assign apsr_upd[gi] = flag_we[gi] ? in_flags[gi] : apsr_reg[gi];
    end
  endgenerate

`ifdef APSR_MSR_WRITE_EN
  assign apsr_next = apsr_wr_en ? apsr_wr_data : apsr_upd;
`else
  assign apsr_next = apsr_upd;
`endif

  always_comb begin
    state_next    = state_reg;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: if (accept) begin
          state_next  = ONE;
          load_out_in = 1'b1;
        end
        ONE: begin
          if (accept && out_ready) begin
            load_out_in = 1'b1;
          end else if (accept) begin
            state_next = TWO;
            load_skid  = 1'b1;
          end else if (out_ready) begin
            state_next = EMPTY;
          end
        end
        TWO: if (out_ready) begin
          state_next    = ONE;
          load_out_skid = 1'b1;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= EMPTY;
      in_ready_reg    <= 1'b1;
      apsr_reg        <= APSR_RESET;
      out_result_reg  <= '0;
      out_rd_reg      <= '0;
      out_wr_en_reg   <= 1'b0;
      skid_result_reg <= '0;
      skid_rd_reg     <= '0;
      skid_wr_en_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != TWO);
      apsr_reg     <= apsr_next;
      if (load_out_in) begin
        out_result_reg <= in_result;
        out_rd_reg     <= in_rd;
        out_wr_en_reg  <= cond_pass;
      end else if (load_out_skid) begin
        out_result_reg <= skid_result_reg;
        out_rd_reg     <= skid_rd_reg;
        out_wr_en_reg  <= skid_wr_en_reg;
      end
      if (load_skid) begin
        skid_result_reg <= in_result;
        skid_rd_reg     <= in_rd;
        skid_wr_en_reg  <= cond_pass;
      end
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = (state_reg != EMPTY);
  assign out_result = out_result_reg;
  assign out_rd     = out_rd_reg;
  assign out_wr_en  = out_wr_en_reg;
  assign apsr_nzcv  = apsr_reg;

endmodule

// File: tb/tb_alu_flag_commit_stage.sv
// Bench for alu_flag_commit_stage: directed plan steps plus random traffic vs a queue model.
module tb_alu_flag_commit_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_flags, in_rd, in_cond;
  logic        in_set_flags, in_logical, flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_wr_en;
  logic [3:0]  apsr_nzcv;
`ifdef APSR_MSR_WRITE_EN
  logic        apsr_wr_en = 1'b0;
  logic [3:0]  apsr_wr_data = 4'h0;
`endif

  always #5 clk = ~clk;

  alu_flag_commit_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_rd(in_rd),
    .in_cond(in_cond), .in_set_flags(in_set_flags), .in_logical(in_logical),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wr_en(out_wr_en),
    .apsr_nzcv(apsr_nzcv)
`ifdef APSR_MSR_WRITE_EN
    , .apsr_wr_en(apsr_wr_en), .apsr_wr_data(apsr_wr_data)
`endif
  );

  typedef struct {
    logic [31:0] r;
    logic [3:0]  rd;
    logic        we;
  } ent_t;

  ent_t       q[$];
  logic [3:0] apsr_m;
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: conditions come in complementary pairs; odd codes invert the base test, except 1111.
  function automatic logic pass_m(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (c[0] && c != 4'hF) ? !base : base;
  endfunction

  // Called at a negedge: apply inputs, advance one cycle, then check at the following negedge.
  task automatic step(input logic v, input logic [31:0] res, input logic [3:0] flg,
                      input logic [3:0] rd, input logic [3:0] cond, input logic s,
                      input logic lg, input logic fsh, input logic ordy);
    logic m_ready, acc, p;
    ent_t e;
    in_valid = v; in_result = res; in_flags = flg; in_rd = rd; in_cond = cond;
    in_set_flags = s; in_logical = lg; flush = fsh; out_ready = ordy;
    m_ready = (q.size() < 2);
    check("in_ready", {31'b0, in_ready}, {31'b0, m_ready});
    acc = v && m_ready && !fsh;
    p   = pass_m(cond, apsr_m);
    @(posedge clk);
    if (fsh) begin
      q.delete();
    end else begin
      if (ordy && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        e.r = res; e.rd = rd; e.we = p;
        q.push_back(e);
        if (p && s) apsr_m = lg ? {flg[3:2], apsr_m[1:0]} : flg;
      end
    end
    @(negedge clk);
    check("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    check("apsr", {28'b0, apsr_nzcv}, {28'b0, apsr_m});
    if (q.size() > 0) begin
      check("out_result", out_result, q[0].r);
      check("out_rd", {28'b0, out_rd}, {28'b0, q[0].rd});
      check("out_wr_en", {31'b0, out_wr_en}, {31'b0, q[0].we});
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_result = 0; in_flags = 0; in_rd = 0; in_cond = 0;
    in_set_flags = 0; in_logical = 0; flush = 0; out_ready = 0;
    apsr_m = 4'b0000;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_rd", {28'b0, out_rd}, 32'd0);
    check("rst_out_wr_en", {31'b0, out_wr_en}, 32'd0);
    check("rst_apsr", {28'b0, apsr_nzcv}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ADDS, AL, result 0
    step(1, 32'd0, 4'b0110, 4'd1, 4'hE, 1, 0, 0, 1);
    check("adds_wr_en", {31'b0, out_wr_en}, 32'd1);
    check("adds_apsr", {28'b0, apsr_nzcv}, 32'h6);
    // NE fails with Z set, then EQ passes
    step(1, 32'h1111, 4'b1000, 4'd2, 4'h1, 1, 0, 0, 1);
    check("ne_wr_en", {31'b0, out_wr_en}, 32'd0);
    check("ne_apsr", {28'b0, apsr_nzcv}, 32'h6);
    step(1, 32'h2222, 4'b1000, 4'd3, 4'h0, 1, 0, 0, 1);
    check("eq_wr_en", {31'b0, out_wr_en}, 32'd1);
    check("eq_apsr", {28'b0, apsr_nzcv}, 32'h8);
    // ANDS preserves C,V
    step(1, 32'h3333, 4'b0011, 4'd4, 4'hE, 1, 0, 0, 1);
    step(1, 32'h4444, 4'b0100, 4'd5, 4'hE, 1, 1, 0, 1);
    check("ands_apsr", {28'b0, apsr_nzcv}, 32'h7);
    step(0, 0, 0, 0, 4'hE, 0, 0, 0, 1);

    // Backpressure: three back-to-back offers with out_ready low
    step(1, 32'hA1, 4'h0, 4'd6, 4'hE, 0, 0, 0, 0);
    step(1, 32'hA2, 4'h0, 4'd7, 4'hE, 0, 0, 0, 0);
    check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    step(1, 32'hA3, 4'h0, 4'd8, 4'hE, 0, 0, 0, 0);
    step(1, 32'hA3, 4'h0, 4'd8, 4'hE, 0, 0, 0, 1);
    check("drain1_result", out_result, 32'hA2);
    step(1, 32'hA3, 4'h0, 4'd8, 4'hE, 0, 0, 0, 1);
    check("third_result", out_result, 32'hA3);
    step(0, 0, 0, 0, 4'hE, 0, 0, 0, 1);

    // Flush while TWO, with a flag-setting instruction presented
    step(1, 32'hB1, 4'h0, 4'd9, 4'hE, 0, 0, 0, 0);
    step(1, 32'hB2, 4'h0, 4'd10, 4'hE, 0, 0, 0, 0);
    step(1, 32'hB3, 4'hF, 4'd11, 4'hE, 1, 0, 1, 0);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_apsr", {28'b0, apsr_nzcv}, 32'h7);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, 4'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
    end

    // Asynchronous reset while TWO
    step(0, 0, 0, 0, 4'hE, 0, 0, 1, 0);
    step(1, 32'hC1, 4'h9, 4'd1, 4'hE, 1, 0, 0, 0);
    step(1, 32'hC2, 4'h9, 4'd2, 4'hE, 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_apsr", {28'b0, apsr_nzcv}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    q.delete();
    apsr_m = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    step(1, 32'hD1, 4'h4, 4'd3, 4'h0, 1, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
